// File: rtl/game_controller_if.sv
// Button inputs and VGA-panel outputs of the Connect-4 sequencer.
// Signal prefixes are from the controller's point of view (slave modport).
interface game_controller_if #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 7
);
    logic                           i_btn_left;
    logic                           i_btn_right;
    logic                           i_btn_drop;
    logic [ROWS-1:0][COLS-1:0][1:0] o_panel;
    logic [COLS-1:0]                o_play;
    logic                           o_player;
    logic [1:0]                     o_winner;
    logic                           o_busy;

    modport master (
        output i_btn_left, i_btn_right, i_btn_drop,
        input  o_panel, o_play, o_player, o_winner, o_busy
    );

    modport slave (
        input  i_btn_left, i_btn_right, i_btn_drop,
        output o_panel, o_play, o_player, o_winner, o_busy
    );
endinterface

// File: rtl/game_controller.sv
// Connect-4 sequencer: cursor, token drop, fixed 4*WIN_LEN-window win scan, draw, turn hand-over.
// Optional macro AUTO_RESTART_EN: a drop pulse in the game-over state starts a new game.
module game_controller #(
    parameter int unsigned ROWS      = 6,
    parameter int unsigned COLS      = 7,
    parameter int unsigned START_COL = 3,
    parameter int unsigned WIN_LEN   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    game_controller_if.slave bus
);
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned CNT_W = $clog2(CELLS + 1);
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned NWIN  = 4 * WIN_LEN;
    localparam int unsigned IW    = $clog2(NWIN);
    localparam int unsigned SW    = $clog2(ROWS + COLS + WIN_LEN) + 2;
    localparam logic signed [SW-1:0] ROWS_S = SW'(ROWS);
    localparam logic signed [SW-1:0] COLS_S = SW'(COLS);

    typedef enum logic [1:0] {StIdle, StCheck, StOver} state_e;
    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

    state_e           r_state,  w_state_d;
    board_t           r_board,  w_board_d;
    logic [CW-1:0]    r_cur,    w_cur_d;
    logic [RW-1:0]    r_row,    w_row_d;
    logic [CW-1:0]    r_col,    w_col_d;
    logic [CNT_W-1:0] r_cnt,    w_cnt_d;
    logic [IW-1:0]    r_idx,    w_idx_d;
    logic             r_win_f,  w_win_f_d;
    logic             r_player, w_player_d;
    logic [1:0]       r_winner, w_winner_d;

    logic [1:0]       w_tok;
    logic [RW-1:0]    w_drop_row;
    logic             w_drop_ok;
    logic             w_hit;

    assign w_tok = r_player ? 2'b10 : 2'b01;

    // Lowest empty row in the cursor column.
    always_comb begin
        w_drop_ok  = 1'b0;
        w_drop_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (r_board[RW'(r)][r_cur] == 2'b00) begin
                w_drop_ok  = 1'b1;
                w_drop_row = RW'(r);
            end
        end
    end

    // Window r_idx: direction = idx / WIN_LEN, offset k = idx % WIN_LEN back from the last token.
    always_comb begin
        int                   dir;
        int                   k;
        logic signed [SW-1:0] cr, cc, sr, sc, kk;
        dir = int'(r_idx) / WIN_LEN;
        k   = int'(r_idx) % WIN_LEN;
        kk  = SW'(k);
        cr  = SW'(r_row);
        cc  = SW'(r_col);
        sr  = '0;
        sc  = '0;
        unique case (dir)
            0: begin sc = SW'(1); cc = cc - kk; end
            1: begin sr = SW'(1); cr = cr - kk; end
            2: begin sr = SW'(1); sc = SW'(1); cr = cr - kk; cc = cc - kk; end
            default: begin sr = SW'(1); sc = '1; cr = cr - kk; cc = cc + kk; end
        endcase
        w_hit = 1'b1;
        for (int j = 0; j < WIN_LEN; j++) begin
            if (cr[SW-1] || cc[SW-1] || cr >= ROWS_S || cc >= COLS_S) begin
                w_hit = 1'b0;
            end else if (r_board[RW'(cr)][CW'(cc)] != w_tok) begin
                w_hit = 1'b0;
            end
            cr = cr + sr;
            cc = cc + sc;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_board_d  = r_board;
        w_cur_d    = r_cur;
        w_row_d    = r_row;
        w_col_d    = r_col;
        w_cnt_d    = r_cnt;
        w_idx_d    = r_idx;
        w_win_f_d  = r_win_f;
        w_player_d = r_player;
        w_winner_d = r_winner;
        unique case (r_state)
            StIdle: begin
                if (bus.i_btn_drop) begin
                    if (w_drop_ok) begin
                        w_board_d[w_drop_row][r_cur] = w_tok;
                        w_row_d   = w_drop_row;
                        w_col_d   = r_cur;
                        w_cnt_d   = r_cnt + 1'b1;
                        w_idx_d   = '0;
                        w_win_f_d = 1'b0;
                        w_state_d = StCheck;
                    end
                end else if (bus.i_btn_left ^ bus.i_btn_right) begin
                    if (bus.i_btn_left) begin
                        w_cur_d = (r_cur == '0) ? CW'(COLS - 1) : r_cur - 1'b1;
                    end else begin
                        w_cur_d = (r_cur == CW'(COLS - 1)) ? '0 : r_cur + 1'b1;
                    end
                end
            end
            StCheck: begin
                w_win_f_d = r_win_f | w_hit;
                w_idx_d   = r_idx + 1'b1;
                if (r_idx == IW'(NWIN - 1)) begin
                    if (r_win_f | w_hit) begin
                        w_winner_d = {r_player, ~r_player};
                        w_state_d  = StOver;
                    end else if (r_cnt == CNT_W'(CELLS)) begin
                        w_winner_d = 2'b11;
                        w_state_d  = StOver;
                    end else begin
                        w_player_d = ~r_player;
                        w_state_d  = StIdle;
                    end
                end
            end
            StOver: begin
`ifdef AUTO_RESTART_EN
                if (bus.i_btn_drop) begin
                    w_board_d  = '0;
                    w_cnt_d    = '0;
                    w_winner_d = 2'b00;
                    w_cur_d    = CW'(START_COL);
                    // The loser opens the next game; player 0 after a draw.
                    w_player_d = (r_winner == 2'b11) ? 1'b0 : ~r_player;
                    w_state_d  = StIdle;
                end
`endif
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_board  <= '0;
            r_cur    <= CW'(START_COL);
            r_row    <= '0;
            r_col    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_win_f  <= 1'b0;
            r_player <= 1'b0;
            r_winner <= 2'b00;
        end else begin
            r_state  <= w_state_d;
            r_board  <= w_board_d;
            r_cur    <= w_cur_d;
            r_row    <= w_row_d;
            r_col    <= w_col_d;
            r_cnt    <= w_cnt_d;
            r_idx    <= w_idx_d;
            r_win_f  <= w_win_f_d;
            r_player <= w_player_d;
            r_winner <= w_winner_d;
        end
    end

    always_comb begin
        bus.o_play = '0;
        if (r_state != StOver) bus.o_play[r_cur] = 1'b1;
    end

    assign bus.o_panel  = r_board;
    assign bus.o_player = r_player;
    assign bus.o_winner = r_winner;
    assign bus.o_busy   = (r_state == StCheck);
endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: a board model pushes expected outputs to a
// scoreboard queue as stimulus is driven; entries are popped and compared once the DUT responds.
module tb_game_controller;
    localparam int ROWS      = 6;
    localparam int COLS      = 7;
    localparam int START_COL = 3;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

    typedef struct {
        string       tag;
        int          kind;
        int          r;
        int          c;
        logic [95:0] exp;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_controller_if #(.ROWS(ROWS), .COLS(COLS)) gif ();

    game_controller #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .START_COL(START_COL),
        .WIN_LEN  (4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (gif.slave)
    );

    board_t     m_board;
    int         m_cur;
    logic       m_player;
    logic [1:0] m_winner;
    bit         m_over;
    int         m_cnt;

    sb_item_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    int vert_cols[7]  = '{3, 4, 3, 4, 3, 4, 3};
    int anti_cols[12] = '{0, 3, 0, 0, 1, 1, 2, 2, 6, 1, 6, 0};

    task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int kind, input int r, input int c,
                           input logic [95:0] exp);
        sb_item_t it;
        it.tag  = tag;
        it.kind = kind;
        it.r    = r;
        it.c    = c;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic push_state(input string tag);
        logic [COLS-1:0] p;
        p = '0;
        if (!m_over) p[m_cur] = 1'b1;
        sb_push({tag, ".play"},   0, 0, 0, 96'(p));
        sb_push({tag, ".player"}, 1, 0, 0, 96'(m_player));
        sb_push({tag, ".winner"}, 2, 0, 0, 96'(m_winner));
        sb_push({tag, ".busy"},   3, 0, 0, 96'(0));
        sb_push({tag, ".panel"},  5, 0, 0, 96'(m_board));
    endtask

    function automatic logic [95:0] observe(input int kind, input int r, input int c);
        case (kind)
            0:       return 96'(gif.o_play);
            1:       return 96'(gif.o_player);
            2:       return 96'(gif.o_winner);
            3:       return 96'(gif.o_busy);
            4:       return 96'(gif.o_panel[r][c]);
            default: return 96'(gif.o_panel);
        endcase
    endfunction

    task automatic drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_val(it.tag, observe(it.kind, it.r, it.c), it.exp);
        end
    endtask

    // Full-board line scan, independent of where the last token landed.
    function automatic bit has_win(input board_t b, input logic [1:0] t);
        int dr, dc, rr, cc;
        bit ok;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int d = 0; d < 4; d++) begin
                    dr = (d == 0) ? 0 : 1;
                    dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                    ok = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        rr = r + i * dr;
                        cc = c + i * dc;
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
                        else if (b[rr][cc] != t) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // Colour of a no-win full board: 2-high stripes, odd columns shifted by 2, column 6 by 1.
    function automatic int pat(input int r, input int c);
        int t;
        t = (c == 6) ? 1 : (c % 2) * 2;
        return (((r + t) % 4) >= 2) ? 1 : 0;
    endfunction

    task automatic pulse(input logic l, input logic r, input logic d);
        @(negedge clk);
        gif.i_btn_left  = l;
        gif.i_btn_right = r;
        gif.i_btn_drop  = d;
        @(negedge clk);
        gif.i_btn_left  = 1'b0;
        gif.i_btn_right = 1'b0;
        gif.i_btn_drop  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_board  = '0;
        m_cur    = START_COL;
        m_player = 1'b0;
        m_winner = 2'b00;
        m_over   = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic move(input logic l, input logic r, input string tag);
        pulse(l, r, 1'b0);
        if (!m_over && (l ^ r)) m_cur = l ? (m_cur + COLS - 1) % COLS : (m_cur + 1) % COLS;
        push_state(tag);
        drain();
    endtask

    task automatic goto_col(input int col);
        int guard;
        guard = 0;
        while (m_cur != col && guard < COLS) begin
            move(1'b0, 1'b1, "goto");
            guard++;
        end
    endtask

    task automatic drop(input string tag, input bit poke_busy);
        int         row;
        int         n;
        logic [1:0] tok;
        row = -1;
        if (!m_over) begin
            for (int r = ROWS - 1; r >= 0; r--) if (m_board[r][m_cur] == 2'b00) row = r;
        end
        pulse(1'b0, 1'b0, 1'b1);
        if (m_over) begin
`ifdef AUTO_RESTART_EN
            m_player = (m_winner == 2'b11) ? 1'b0 : ~m_player;
            m_board  = '0;
            m_cnt    = 0;
            m_winner = 2'b00;
            m_over   = 1'b0;
            m_cur    = START_COL;
`endif
            push_state({tag, ".over"});
            drain();
            return;
        end
        if (row < 0) begin
            push_state({tag, ".full"});
            drain();
            return;
        end
        tok = m_player ? 2'b10 : 2'b01;
        m_board[row][m_cur] = tok;
        m_cnt++;
        sb_push({tag, ".busy"}, 3, 0, 0, 96'(1));
        sb_push({tag, ".cell"}, 4, row, m_cur, 96'(tok));
        drain();
        n = 0;
        while (gif.o_busy === 1'b1 && n < 40) begin
            gif.i_btn_drop = (poke_busy && n == 4);
            n++;
            @(negedge clk);
        end
        gif.i_btn_drop = 1'b0;
        check_val({tag, ".busy_len"}, 96'(n), 96'(16));
        if (has_win(m_board, tok)) begin
            m_winner = m_player ? 2'b10 : 2'b01;
            m_over   = 1'b1;
        end else if (m_cnt == ROWS * COLS) begin
            m_winner = 2'b11;
            m_over   = 1'b1;
        end else begin
            m_player = ~m_player;
        end
        push_state(tag);
        drain();
    endtask

    task automatic play_draw();
        int h[COLS];
        int sel;
        foreach (h[i]) h[i] = 0;
        for (int mv = 0; mv < ROWS * COLS; mv++) begin
            sel = -1;
            for (int c = COLS - 1; c >= 0; c--) begin
                if (h[c] < ROWS && pat(h[c], c) == int'(m_player)) sel = c;
            end
            if (sel < 0) begin
                n_err++;
                $display("FAIL draw.plan: no column for player %0d at move %0d", m_player, mv);
                return;
            end
            goto_col(sel);
            drop("draw", 1'b0);
            h[sel]++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        gif.i_btn_left  = 1'b0;
        gif.i_btn_right = 1'b0;
        gif.i_btn_drop  = 1'b0;
        repeat (2) @(negedge clk);

        do_reset();
        push_state("reset");
        drain();

        for (int i = 0; i < 4; i++) move(1'b0, 1'b1, "cur.right");
        move(1'b1, 1'b1, "cur.both");
        move(1'b1, 1'b0, "cur.left_wrap");
        move(1'b0, 1'b1, "cur.right_wrap");

        do_reset();
        foreach (vert_cols[i]) begin
            goto_col(vert_cols[i]);
            drop("vert", 1'b0);
        end
        sb_push("vert.cell33", 4, 3, 3, 96'(2'b01));
        drain();
        move(1'b0, 1'b1, "vert.over_move");
        drop("vert.post", 1'b0);

        do_reset();
        goto_col(0);
        for (int i = 0; i < ROWS + 1; i++) drop("full", 1'b0);

        do_reset();
        foreach (anti_cols[i]) begin
            goto_col(anti_cols[i]);
            drop("anti", (i == 4));
        end

        do_reset();
        pulse(1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        sb_push("midrst.busy", 3, 0, 0, 96'(1));
        drain();
        do_reset();
        push_state("midrst");
        drain();
        drop("midrst.redrop", 1'b0);

        do_reset();
        play_draw();
        drop("draw.post", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
